// File: rtl/core_hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_hazard_pkg
//  Description : Shared types and helpers for the decode-stage load-use
//                hazard scoreboard: entry layout, default sizing and the
//                per-entry source match rule.
//  Revision    : 1.0  initial release
// ============================================================================
package core_hazard_pkg;

    // Entries hold register indices zero-extended to this width, so one entry
    // type serves every ADDR_WIDTH up to this limit.
    localparam int SB_ADDR_WIDTH   = 8;
    localparam int DEFAULT_DEPTH   = 4;
    localparam int DEFAULT_TIMEOUT = 255;

    typedef struct packed {
        logic                     valid;
        logic [SB_ADDR_WIDTH-1:0] rd;
        logic                     fp;
    } sb_entry_t;

    // A source hits an entry when it is active, the entry is live, and both the
    // register index and register-file select agree. Integer x0 is hardwired to
    // zero and can never carry a hazard; FP f0 is an ordinary register.
    function automatic logic src_match(
        input sb_entry_t                entry,
        input logic [SB_ADDR_WIDTH-1:0] rs,
        input logic                     fp,
        input logic                     active
    );
        logic is_x0;
        is_x0 = !fp && (rs == '0);
        return active && entry.valid && (entry.rd == rs) && (entry.fp == fp) && !is_x0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_src_compare.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_src_compare
//  Description : Compares one decode source operand against every scoreboard
//                entry plus the load issuing this cycle; yields one match bit.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_src_compare
    import core_hazard_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = DEFAULT_DEPTH
) (
    input  sb_entry_t [DEPTH-1:0]  entries,
    input  logic      [DEPTH-1:0]  retire_mask,
    input  sb_entry_t              issue_entry,
    input  logic [ADDR_WIDTH-1:0]  src_rd,
    input  logic                   src_fp,
    input  logic                   src_active,
    output logic                   match
);

    logic [SB_ADDR_WIDTH-1:0] src_ext;

    // Widen the source index, then OR the bypass hit with every live entry hit.
    // The entry retiring this cycle is skipped: writeback forwarding supplies it.
    always_comb begin
        src_ext                 = '0;
        src_ext[ADDR_WIDTH-1:0] = src_rd;
        match = src_match(issue_entry, src_ext, src_fp, src_active);
        for (int i = 0; i < DEPTH; i++) begin
            if (!retire_mask[i] && src_match(entries[i], src_ext, src_fp, src_active)) begin
                match = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/load_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : load_hazard_scoreboard
//  Description : In-order scoreboard of outstanding variable-latency loads.
//                Stalls decode (and requests a NOP) while any active source
//                depends on a pending load; adds flush, occupancy, a sticky
//                stall watchdog and a sticky retire-underflow flag.
//  Revision    : 1.0  initial release
// ============================================================================
module load_hazard_scoreboard
    import core_hazard_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int NUM_SRC    = 3,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          issue_valid,
    input  logic [ADDR_WIDTH-1:0]         issue_rd,
    input  logic                          issue_fp,
    output logic                          issue_ready,
    input  logic                          done_valid,
    input  logic [NUM_SRC*ADDR_WIDTH-1:0] rs,
    input  logic [NUM_SRC-1:0]            rs_active,
    input  logic [NUM_SRC-1:0]            rs_fp,
    output logic                          load_hazard_stall,
    output logic                          nop_req,
    output logic [$clog2(DEPTH):0]        occupancy,
    output logic                          stall_timeout,
    output logic                          underflow
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int STALL_W = $clog2(TIMEOUT + 1);

    sb_entry_t [DEPTH-1:0] entries;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [STALL_W-1:0]    stall_cnt;
    logic                  timeout_flag;
    logic                  underflow_flag;

    logic                  accept;
    logic                  retire;
    logic [DEPTH-1:0]      retire_mask;
    sb_entry_t             issue_entry;
    logic [NUM_SRC-1:0]    src_hit;

    // Handshake and retire qualification come from registered state only, so a
    // same-cycle done never opens a slot for a same-cycle issue.
    always_comb begin
        issue_ready       = (count != CNT_W'(DEPTH));
        accept            = issue_valid && issue_ready;
        retire            = done_valid && (count != '0);
        retire_mask       = '0;
        retire_mask[rd_ptr] = retire;
        issue_entry       = '0;
        issue_entry.valid = accept;
        issue_entry.rd[ADDR_WIDTH-1:0] = issue_rd;
        issue_entry.fp    = issue_fp;
    end

    generate
        for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
            hazard_src_compare #(
                .ADDR_WIDTH (ADDR_WIDTH),
                .DEPTH      (DEPTH)
            ) u_cmp (
                .entries     (entries),
                .retire_mask (retire_mask),
                .issue_entry (issue_entry),
                .src_rd      (rs[s*ADDR_WIDTH +: ADDR_WIDTH]),
                .src_fp      (rs_fp[s]),
                .src_active  (rs_active[s]),
                .match       (src_hit[s])
            );
        end
    endgenerate

    // Any source hit stalls decode; the bubble request mirrors the stall.
    always_comb begin
        load_hazard_stall = |src_hit;
        nop_req           = load_hazard_stall;
        occupancy         = count;
        stall_timeout     = timeout_flag;
        underflow         = underflow_flag;
    end

    // Circular buffer: write at wr_ptr on accept, invalidate at rd_ptr on retire;
    // flush discards everything including a same-cycle issue or done.
    always_ff @(posedge clk) begin
        if (rst) begin
            entries <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else if (flush) begin
            entries <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            if (accept) begin
                entries[wr_ptr] <= issue_entry;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (retire) begin
                entries[rd_ptr].valid <= 1'b0;
                rd_ptr                <= rd_ptr + PTR_W'(1);
            end
            case ({accept, retire})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky flag for a writeback arriving with nothing outstanding.
    always_ff @(posedge clk) begin
        if (rst) begin
            underflow_flag <= 1'b0;
        end else if (done_valid && (count == '0)) begin
            underflow_flag <= 1'b1;
        end
    end

    // Watchdog: count consecutive stall cycles, saturating; latch the timeout
    // on the edge where the count reaches TIMEOUT. Only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt    <= '0;
            timeout_flag <= 1'b0;
        end else if (load_hazard_stall) begin
            if (stall_cnt != STALL_W'(TIMEOUT)) begin
                stall_cnt <= stall_cnt + STALL_W'(1);
            end
            if (stall_cnt == STALL_W'(TIMEOUT - 1)) begin
                timeout_flag <= 1'b1;
            end
        end else begin
            stall_cnt <= '0;
        end
    end

    // An issue offered while full is dropped; flag it in simulation.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(issue_valid && !issue_ready))
                else $warning("load_hazard_scoreboard: issue dropped while full");
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_hazard_scoreboard
//  Description : Directed-vector bench; expectations are queued by the
//                stimulus and checked by an independent monitor.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_load_hazard_scoreboard;

    localparam int AW = 5;
    localparam int NS = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          issue_valid;
    logic [AW-1:0] issue_rd;
    logic          issue_fp;
    logic          issue_ready;
    logic          done_valid;
    logic [NS*AW-1:0] rs;
    logic [NS-1:0] rs_active;
    logic [NS-1:0] rs_fp;
    logic          load_hazard_stall;
    logic          nop_req;
    logic [2:0]    occupancy;
    logic          stall_timeout;
    logic          underflow;

    typedef struct {
        string name;
        logic  stall;
        logic  ready;
        int    occ;
        logic  to;
        logic  uf;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    load_hazard_scoreboard #(
        .ADDR_WIDTH (AW),
        .DEPTH      (4),
        .NUM_SRC    (NS),
        .TIMEOUT    (8)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .issue_valid       (issue_valid),
        .issue_rd          (issue_rd),
        .issue_fp          (issue_fp),
        .issue_ready       (issue_ready),
        .done_valid        (done_valid),
        .rs                (rs),
        .rs_active         (rs_active),
        .rs_fp             (rs_fp),
        .load_hazard_stall (load_hazard_stall),
        .nop_req           (nop_req),
        .occupancy         (occupancy),
        .stall_timeout     (stall_timeout),
        .underflow         (underflow)
    );

    always #5 clk = ~clk;

    // Monitor: outputs are stable mid-cycle; pop one expectation per cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_cmp++;
            if (load_hazard_stall !== e.stall || nop_req !== e.stall ||
                issue_ready !== e.ready || int'(occupancy) != e.occ ||
                stall_timeout !== e.to || underflow !== e.uf) begin
                n_mis++;
                $display("FAIL %s: got stall=%0b nop=%0b ready=%0b occ=%0d to=%0b uf=%0b, want stall=%0b nop=%0b ready=%0b occ=%0d to=%0b uf=%0b",
                         e.name, load_hazard_stall, nop_req, issue_ready, occupancy,
                         stall_timeout, underflow, e.stall, e.stall, e.ready, e.occ, e.to, e.uf);
            end
        end
    end

    task automatic set_in(input logic iv, input int ird, input logic ifp,
                          input logic dv, input logic fl,
                          input int s0, input int s1, input int s2,
                          input logic [2:0] act, input logic [2:0] fp);
        issue_valid = iv;
        issue_rd    = AW'(ird);
        issue_fp    = ifp;
        done_valid  = dv;
        flush       = fl;
        rs          = {AW'(s2), AW'(s1), AW'(s0)};
        rs_active   = act;
        rs_fp       = fp;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000);
    endtask

    // Queue the expectation for the cycle whose inputs are already driven,
    // then advance to just after the next rising edge.
    task automatic cyc(input string nm, input logic st, input logic rdy,
                       input int oc, input logic to, input logic uf);
        exp_t e;
        e.name = nm; e.stall = st; e.ready = rdy; e.occ = oc; e.to = to; e.uf = uf;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ret;
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("reset", 0, 1, 0, 0, 0);

        // Basic load-use on x5 including same-cycle bypass and release on done.
        set_in(1, 5, 0, 0, 0, 5, 0, 0, 3'b001, 3'b000); cyc("same_cyc_issue", 1, 1, 0, 0, 0);
        set_in(0, 0, 0, 0, 0, 5, 0, 0, 3'b001, 3'b000); cyc("outstanding",    1, 1, 1, 0, 0);
        set_in(0, 0, 0, 1, 0, 5, 0, 0, 3'b001, 3'b000); cyc("done_release",   0, 1, 1, 0, 0);
        set_in(0, 0, 0, 0, 0, 5, 0, 0, 3'b001, 3'b000); cyc("after_retire",   0, 1, 0, 0, 0);

        // x0 never hazards, f0 does.
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 3'b001, 3'b000); cyc("x0_issue",   0, 1, 0, 0, 0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 3'b001, 3'b000); cyc("x0_pending", 0, 1, 1, 0, 0);
        set_in(1, 0, 1, 0, 0, 0, 0, 0, 3'b010, 3'b010); cyc("f0_issue",   1, 1, 1, 0, 0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 3'b010, 3'b000); cyc("x0_int_src", 0, 1, 2, 0, 0);
        set_in(0, 0, 0, 1, 0, 0, 0, 0, 3'b000, 3'b000); cyc("drain_a",    0, 1, 2, 0, 0);
        set_in(0, 0, 0, 1, 0, 0, 0, 0, 3'b000, 3'b000); cyc("drain_b",    0, 1, 1, 0, 0);

        // Fill to capacity, drop on full, issue+done at occupancy 3.
        for (int k = 0; k < 4; k++) begin
            set_in(1, k + 1, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000);
            cyc("fill", 0, 1, k, 0, 0);
        end
        set_in(1, 6, 0, 0, 0, 6, 0, 0, 3'b001, 3'b000); cyc("full_drop",       0, 0, 4, 0, 0);
        set_in(0, 0, 0, 0, 0, 6, 0, 0, 3'b001, 3'b000); cyc("drop_not_stored", 0, 0, 4, 0, 0);
        set_in(0, 0, 0, 0, 0, 4, 0, 0, 3'b001, 3'b000); cyc("x4_pending",      1, 0, 4, 0, 0);
        set_in(0, 0, 0, 1, 0, 0, 0, 0, 3'b000, 3'b000); cyc("done_from_full",  0, 0, 4, 0, 0);
        set_in(1, 9, 0, 1, 0, 0, 0, 0, 3'b000, 3'b000); cyc("issue_done_occ3", 0, 1, 3, 0, 0);
        idle();                                         cyc("occ_hold",        0, 1, 3, 0, 0);

        // Ten issue/done pairs wrap both pointers; FIFO order x3,x4,x9,x10...
        for (int k = 0; k < 10; k++) begin
            ret = (k == 0) ? 3 : (k == 1) ? 4 : (k == 2) ? 9 : (10 + k - 3);
            if (k % 2 == 0) begin
                set_in(1, 10 + k, 0, 1, 0, 10 + k, 0, 0, 3'b001, 3'b000);
                cyc("wrap_bypass", 1, 1, 3, 0, 0);
            end else begin
                set_in(1, 10 + k, 0, 1, 0, 0, ret, 0, 3'b010, 3'b000);
                cyc("wrap_retire_excl", 0, 1, 3, 0, 0);
            end
        end
        for (int k = 3; k > 0; k--) begin
            set_in(0, 0, 0, 1, 0, 0, 0, 0, 3'b000, 3'b000);
            cyc("wrap_drain", 0, 1, k, 0, 0);
        end

        // Duplicate destinations on x7 via rs3.
        set_in(1, 7, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000); cyc("dup_issue_a",     0, 1, 0, 0, 0);
        set_in(1, 7, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000); cyc("dup_issue_b",     0, 1, 1, 0, 0);
        set_in(0, 0, 0, 0, 0, 0, 0, 7, 3'b100, 3'b000); cyc("dup_both",        1, 1, 2, 0, 0);
        set_in(0, 0, 0, 1, 0, 0, 0, 7, 3'b100, 3'b000); cyc("dup_first_done",  1, 1, 2, 0, 0);
        set_in(0, 0, 0, 1, 0, 0, 0, 7, 3'b100, 3'b000); cyc("dup_second_done", 0, 1, 1, 0, 0);
        set_in(0, 0, 0, 0, 0, 0, 0, 7, 3'b100, 3'b000); cyc("dup_clear",       0, 1, 0, 0, 0);

        // Flush with a same-cycle issue, then underflow on a later done.
        for (int k = 0; k < 3; k++) begin
            set_in(1, 11 + k, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000);
            cyc("pre_flush", 0, 1, k, 0, 0);
        end
        set_in(1, 14, 0, 0, 1, 0, 0, 0, 3'b000, 3'b000);  cyc("flush_issue",   0, 1, 3, 0, 0);
        set_in(0, 0, 0, 0, 0, 14, 11, 0, 3'b011, 3'b000); cyc("post_flush",    0, 1, 0, 0, 0);
        set_in(0, 0, 0, 1, 0, 0, 0, 0, 3'b000, 3'b000);   cyc("done_empty",    0, 1, 0, 0, 1'b0);
        idle();                                           cyc("underflow_set", 0, 1, 0, 0, 1);

        // Watchdog: eight consecutive stalled cycles on x20.
        set_in(1, 20, 0, 0, 0, 20, 0, 0, 3'b001, 3'b000); cyc("wd_stall_1", 1, 1, 0, 0, 1);
        for (int k = 2; k <= 8; k++) begin
            set_in(0, 0, 0, 0, 0, 20, 0, 0, 3'b001, 3'b000);
            cyc("wd_stall", 1, 1, 1, 0, 1);
        end
        idle();                                         cyc("wd_timeout_set",  0, 1, 1, 1, 1);
        set_in(0, 0, 0, 0, 1, 0, 0, 0, 3'b000, 3'b000); cyc("wd_flush_keeps",  0, 1, 1, 1, 1);
        idle();                                         cyc("wd_sticky",       0, 1, 0, 1, 1);

        // Mid-operation reset clears everything.
        set_in(1, 21, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000); cyc("pre_rst", 0, 1, 0, 1, 1);
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("after_rst", 0, 1, 0, 0, 0);
        set_in(0, 0, 0, 0, 0, 21, 0, 0, 3'b001, 3'b000); cyc("rst_forgets", 0, 1, 0, 0, 0);
        idle();

        for (int k = 0; k < 5 && q.size() > 0; k++) @(posedge clk);
        if (q.size() > 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL drain_queue: %0d expectations left unchecked, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_hazard_scoreboard.md
Name: load_hazard_scoreboard

Overview:
- Parametrised successor to the decode-stage load-use hazard check.
- Tracks up to DEPTH outstanding variable-latency loads (integer or FP destination) in an in-order scoreboard.
- Stalls decode and requests a NOP while any active source operand matches a pending load destination.
- Sits in decode. It is fed by the execute/LSU issue path and the writeback completion path, and adds flush, occupancy, and stall-watchdog behaviour.

Parameters:
- ADDR_WIDTH, 5, register index width.
- DEPTH, 4, max outstanding loads; power of two, at least 2.
- NUM_SRC, 3, source operands checked per decode instruction (rs1, rs2, rs3 for fused FP ops).
- TIMEOUT, 255, stall-cycle count that raises stall_timeout; at least 1.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  pipeline flush; clears all entries.
- issue_valid  in  1  a load leaves execute towards the LSU this cycle.
- issue_rd  in  ADDR_WIDTH  load destination.
- issue_fp  in  1  destination is in the FP register file.
- issue_ready  out  1  scoreboard can accept an issue.
- done_valid  in  1  oldest outstanding load writes back this cycle.
- rs  in  NUM_SRC*ADDR_WIDTH  decode sources; source i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- rs_active  in  NUM_SRC  per-source valid.
- rs_fp  in  NUM_SRC  per-source register-file select.
- load_hazard_stall  out  1  stall fetch/decode.
- nop_req  out  1  inject a bubble into execute.
- occupancy  out  $clog2(DEPTH)+1  valid entry count.
- stall_timeout  out  1  sticky watchdog flag.
- underflow  out  1  sticky flag: done_valid seen with the scoreboard empty.

Behaviour:
- Reset: single clock domain. rst is synchronous and active-high; it is sampled on the rising edge of clk.
- Reset values: all entries invalid, pointers 0, occupancy 0, stall counter 0, stall_timeout 0, underflow 0. issue_ready is 1 after reset. load_hazard_stall and nop_req are 0 after reset, given no issue_valid.
- Storage: circular buffer of DEPTH entries {valid, rd, fp}.
  - Write pointer advances on an accepted issue (issue_valid & issue_ready).
  - Read pointer advances on done_valid when not empty.
  - Both pointers wrap modulo DEPTH.
- issue_ready = (occupancy != DEPTH). It is registered-state only and does not depend on a same-cycle done.
- issue_valid while not ready: the issue is dropped, state is unchanged, and a simulation assertion fires.
- Simultaneous accepted issue and done: occupancy is unchanged and both pointers advance.
- Integer rd = 0 issue: accepted and occupies a slot, but never matches (x0 is never a hazard). FP f0 does match.
- Match rule: source i matches an entry when all of the following hold:
  - rs_active[i] = 1;
  - rs[i] == rd and rs_fp[i] == fp;
  - the entry is valid;
  - the entry is not the one retiring this cycle, because writeback forwarding covers it.
- Same-cycle issue: the load issuing this cycle is also a match candidate, through a combinational compare against issue_rd/issue_fp, preserving the one-cycle load-use rule.
- load_hazard_stall = any match on any source; nop_req = load_hazard_stall. Both are combinational, with zero latency.
- Duplicate destinations: two outstanding loads to the same rd are allowed. The hazard holds until the last one retires.
- Flush: on flush, all entries are invalidated next cycle and occupancy becomes 0. Flush has priority over a same-cycle issue (the issue is discarded).
  - A same-cycle done is also discarded.
  - Later done_valid with the scoreboard empty sets underflow; occupancy stays 0.
- Watchdog: stall counter increments each cycle load_hazard_stall = 1 and clears on any non-stall cycle. It saturates at TIMEOUT.
  - stall_timeout sets when the counter reaches TIMEOUT and holds until rst. flush does not clear it.
- Reset mid-operation: all state returns to reset values on the next edge. In-flight loads are forgotten.

Decomposition:
- core_hazard_pkg holds:
  - typedef sb_entry_t {logic valid; logic [ADDR_WIDTH-1:0] rd; logic fp;};
  - localparam defaults for DEPTH and TIMEOUT;
  - function src_match(entry, rs, fp, active), which includes the x0 exclusion.
- Sub-module: hazard_src_compare. It compares one source against all entries plus the issue bypass and returns one match bit. It is instantiated NUM_SRC times via generate.

Test Plan:
- Issue rd=x5 int; same cycle rs1=x5 active -> stall=1, nop_req=1. Next cycle, still outstanding -> stall=1. done_valid -> stall=0 that same cycle.
- Issue rd=x0 int, then rs1=x0 active -> stall=0 throughout, occupancy=1. Issue rd=f0 FP with rs2=f0, rs_fp=1 -> stall=1. rs2=x0 int -> stall=0.
- Fill 4 loads (x1..x4) -> occupancy=4, issue_ready=0. Issue x6 is dropped. Issue+done same cycle at occupancy=3 -> occupancy stays 3. Pointer wrap verified over 10 issue/done pairs.
- Two loads to x7, rs3=x7 active -> stall held through first done, released on second done.
- Three outstanding loads; flush with simultaneous issue -> occupancy=0 next cycle, stall=0. Subsequent done_valid -> underflow=1, occupancy=0.
- TIMEOUT=8: hold hazard for 8 cycles -> stall_timeout=1 on the 8th stalled cycle and stays 1 after the stall clears. rst -> all outputs 0 and issue_ready=1.
